std_stream_serializer: RTL and testbench
========================================

// Module: std_stream_serializer
// PURPOSE
//  Width-down converter on std_stream_intf: accepts one wide word on data_in and
//  emits it as RATIO narrow beats on data_out, with a last flag on the final beat.
//  Counterpart of the stream pipeline stage: sits at the narrow end of a datapath
//  (e.g. wide memory word -> byte-wide link). Registered output; zero-bubble
//  back-to-back words at full throughput.
// PARAMETERS
//  RATIO      4  beats per input word; >=1; $bits(data_in.payload)==RATIO*$bits(data_out.payload)
//  MSB_FIRST  0  0: beat 0 = payload[OUT_W-1:0]; 1: beat 0 = payload[IN_W-1 -: OUT_W]
// PORTS
//  clk       in   1            clock, all state on posedge
//  rst       in   1            asynchronous, active-low reset
//  data_in   in   intf IN_W    std_stream_intf.in: valid/ready/payload, wide words
//  data_out  out  intf OUT_W   std_stream_intf.out: valid/ready/payload, narrow beats
//  last      out  1            high with data_out.valid on beat RATIO-1 of each word
//  busy      out  1            high while a word is held (data_out.valid)
// BEHAVIOUR
//  - Reset (rst low, async): data_out.valid=0, last=0, busy=0, beat counter=0,
//    shift register=0. data_in.ready is combinational and reads 1 during reset release.
//  - STATIC_ASSERT on width relation; RATIO==1 degenerates to a 1-deep registered stage.
//  - State: held (1b), beat cnt ($clog2(RATIO) bits, min 1), shift reg IN_W bits.
//    EMPTY (held=0) and SENDING (held=1, cnt=0..RATIO-1).
//  - data_in.ready = !held || (data_out.ready && cnt==RATIO-1).
//  - Input handshake (valid&&ready): load shift reg with payload, cnt<=0, held<=1.
//    Latency: first beat visible on data_out the cycle after acceptance.
//  - Output handshake (data_out.valid&&ready), cnt<RATIO-1: shift by OUT_W toward the
//    beat-0 end, cnt<=cnt+1.
//  - Output handshake with cnt==RATIO-1: if input handshake same cycle, load new word
//    (cnt<=0, held stays 1, no bubble); else held<=0, cnt<=0.
//  - data_out.payload = beat-0 slice of shift reg; data_out.valid = held;
//    last = held && cnt==RATIO-1; busy = held.
//  - Payload, last stable while data_out.valid && !data_out.ready (AXI-style hold).
//  - No combinational path data_in.valid -> data_out.*; only data_out.ready -> data_in.ready.
//  - cnt never exceeds RATIO-1; no wrap past a word boundary (non-power-of-2 RATIO legal).
//  - Reset asserted mid-word: partial word discarded, no further beats emitted.
//  - data_in.payload ignored unless handshaking; X on payload while !valid harmless.
// TESTING
//  1 RATIO=4,OUT_W=8, word 0xDDCCBBAA, sink always ready -> beats AA,BB,CC,DD on
//    4 consecutive cycles starting 1 cycle after accept; last only on DD.
//  2 Same, MSB_FIRST=1 -> beats DD,CC,BB,AA; last on AA.
//  3 Continuous source of 0x03020100,0x07060504 with ready=1 -> 8 beats 00..07 in 8
//    consecutive cycles, data_in.ready=1 only in the cycle of each last beat.
//  4 Random sink backpressure (ready 30%) -> payload/last held stable while stalled,
//    byte stream matches scoreboard exactly, no drops or duplicates.
//  5 rst low after beat 1 of 0x44332211 -> valid/last/busy drop immediately
//    (async); after release, next word 0x88776655 serialises cleanly 55,66,77,88.
//  6 RATIO=3 and RATIO=1 builds: 3 beats with last on third; RATIO=1 acts as a
//    register stage, last=valid every beat, full throughput.

Source files
------------

// File: rtl/std_stream_serializer_if.sv
// Valid/ready stream bundle with a parameterised payload width.
// The producer side uses the master modport, the consumer side uses slave.
interface std_stream_intf #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport master (output valid, output payload, input  ready);
  modport slave  (input  valid, input  payload, output ready);
endinterface

// File: rtl/std_stream_serializer.sv
// Width-down converter: one wide word in, RATIO narrow beats out, last on the final beat.
// Back-to-back words stream with no bubble; output state comes straight from flops.
module std_stream_serializer #(
  parameter int OUT_W     = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  std_stream_intf.slave      data_in,
  std_stream_intf.master     data_out,
  output logic               last,
  output logic               busy
);

  localparam int IN_W  = RATIO * OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if (RATIO < 1 || $bits(data_in.payload) != IN_W || $bits(data_out.payload) != OUT_W)
    begin : g_width_check
      $error("std_stream_serializer: payload widths must satisfy IN_W == RATIO*OUT_W, RATIO >= 1");
    end
  endgenerate

  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  shift_q, shift_d;

  logic last_beat;
  logic in_hs;
  logic out_hs;

  assign last_beat     = (cnt_q == CNT_LAST);
  assign data_in.ready = !held_q || (data_out.ready && last_beat);
  assign in_hs         = data_in.valid && data_in.ready;
  assign out_hs        = held_q && data_out.ready;

  always_comb begin
    held_d  = held_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (out_hs) begin
      if (!last_beat) begin
        // Move the next beat into the slice that drives the output.
        shift_d = MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        held_d = 1'b0;
        cnt_d  = '0;
      end
    end
    // A same-cycle accept on the final beat overrides the drain: no bubble.
    if (in_hs) begin
      shift_d = data_in.payload;
      cnt_d   = '0;
      held_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign data_out.payload = shift_q[IN_W-1 -: OUT_W];
    end else begin : g_lsb
      assign data_out.payload = shift_q[OUT_W-1:0];
    end
  endgenerate

  assign data_out.valid = held_q;
  assign last           = held_q && last_beat;
  assign busy           = held_q;

endmodule

// File: tb/tb_std_stream_serializer.sv
// Directed bench for the stream serializer: LSB/MSB-first RATIO=4, RATIO=3 and RATIO=1 builds.
module tb_std_stream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  std_stream_intf #(.W(32)) a_in ();
  std_stream_intf #(.W(8))  a_out ();
  std_stream_intf #(.W(32)) b_in ();
  std_stream_intf #(.W(8))  b_out ();
  std_stream_intf #(.W(24)) c_in ();
  std_stream_intf #(.W(8))  c_out ();
  std_stream_intf #(.W(8))  d_in ();
  std_stream_intf #(.W(8))  d_out ();

  logic a_last, a_busy, b_last, b_busy, c_last, c_busy, d_last, d_busy;

  std_stream_serializer #(.OUT_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(a_in), .data_out(a_out), .last(a_last), .busy(a_busy));
  std_stream_serializer #(.OUT_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .data_in(b_in), .data_out(b_out), .last(b_last), .busy(b_busy));
  std_stream_serializer #(.OUT_W(8), .RATIO(3), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .data_in(c_in), .data_out(c_out), .last(c_last), .busy(c_busy));
  std_stream_serializer #(.OUT_W(8), .RATIO(1), .MSB_FIRST(1'b0)) u_d (
    .clk(clk), .rst(rst), .data_in(d_in), .data_out(d_out), .last(d_last), .busy(d_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [3];
  logic [8:0]  sbq [$];
  logic [8:0]  ent;
  int          widx;
  int          pops;
  int          cyc_cnt;
  bit          done;
  logic        stall_prev;
  logic [7:0]  pay_prev;
  logic        last_prev;

  initial begin
    a_in.valid = 1'b0; a_in.payload = '0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.payload = '0; b_out.ready = 1'b1;
    c_in.valid = 1'b0; c_in.payload = '0; c_out.ready = 1'b1;
    d_in.valid = 1'b0; d_in.payload = '0; d_out.ready = 1'b1;

    // Reset state
    #2;
    chk("rst_a_valid", a_out.valid, 1'b0);
    chk("rst_a_last",  a_last,      1'b0);
    chk("rst_a_busy",  a_busy,      1'b0);
    chk("rst_a_ready", a_in.ready,  1'b1);
    chk("rst_b_busy",  b_busy,      1'b0);
    chk("rst_c_valid", c_out.valid, 1'b0);
    chk("rst_d_valid", d_out.valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // Test 1: LSB-first, sink always ready
    a_in.payload = 32'hDDCCBBAA;
    a_in.valid   = 1'b1;
    #1 chk("t1_ready_idle", a_in.ready, 1'b1);
    cyc();
    a_in.valid   = 1'b0;
    a_in.payload = 'x;
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid",   a_out.valid,   1'b1);
      chk("t1_payload", a_out.payload, (32'hAA + 32'h11 * i) & 32'hFF);
      chk("t1_last",    a_last,        (i == 3));
      chk("t1_busy",    a_busy,        1'b1);
      chk("t1_ready",   a_in.ready,    (i == 3));
      cyc();
    end
    chk("t1_end_valid", a_out.valid, 1'b0);
    chk("t1_end_last",  a_last,      1'b0);
    chk("t1_end_busy",  a_busy,      1'b0);

    // Test 3: back-to-back words, no bubble
    a_in.payload = 32'h03020100;
    a_in.valid   = 1'b1;
    cyc();
    a_in.payload = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) a_in.valid = 1'b0;
      chk("t3_valid",   a_out.valid,   1'b1);
      chk("t3_payload", a_out.payload, k);
      chk("t3_last",    a_last,        (k % 4 == 3));
      chk("t3_ready",   a_in.ready,    (k % 4 == 3));
      cyc();
    end
    chk("t3_end_valid", a_out.valid, 1'b0);

    // Test 4: random backpressure against a scoreboard
    words[0] = 32'h1F2E3D4C;
    words[1] = 32'hA5B6C7D8;
    words[2] = 32'h01234567;
    widx = 0; pops = 0; cyc_cnt = 0; done = 1'b0;
    while (!done && cyc_cnt < 600) begin
      a_out.ready  = ($urandom_range(0, 99) < 30);
      a_in.valid   = (widx < 3);
      a_in.payload = (widx < 3) ? words[widx] : 32'h0;
      #1;
      if (a_out.valid && a_out.ready) begin
        if (sbq.size() == 0) begin
          chk("t4_extra_beat", 1'b1, 1'b0);
        end else begin
          ent = sbq.pop_front();
          chk("t4_payload", a_out.payload, ent[7:0]);
          chk("t4_last",    a_last,        ent[8]);
        end
        pops++;
      end
      if (a_in.valid && a_in.ready) begin
        for (int k = 0; k < 4; k++) sbq.push_back({(k == 3), words[widx][8*k +: 8]});
        widx++;
      end
      stall_prev = a_out.valid && !a_out.ready;
      pay_prev   = a_out.payload;
      last_prev  = a_last;
      cyc();
      cyc_cnt++;
      if (stall_prev) begin
        chk("t4_hold_valid",   a_out.valid,   1'b1);
        chk("t4_hold_payload", a_out.payload, pay_prev);
        chk("t4_hold_last",    a_last,        last_prev);
      end
      done = (widx == 3 && sbq.size() == 0 && !a_out.valid);
    end
    chk("t4_done", done, 1'b1);
    chk("t4_pops", pops, 12);
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    cyc();

    // Test 5: async reset mid-word, then a clean word
    a_in.payload = 32'h44332211;
    a_in.valid   = 1'b1;
    cyc();
    a_in.valid = 1'b0;
    chk("t5_beat0", a_out.payload, 8'h11);
    cyc();
    chk("t5_beat1", a_out.payload, 8'h22);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", a_out.valid, 1'b0);
    chk("t5_rst_last",  a_last,      1'b0);
    chk("t5_rst_busy",  a_busy,      1'b0);
    chk("t5_rst_ready", a_in.ready,  1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("t5_post_valid", a_out.valid, 1'b0);
    a_in.payload = 32'h88776655;
    a_in.valid   = 1'b1;
    cyc();
    a_in.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_payload", a_out.payload, (32'h55 + 32'h11 * i) & 32'hFF);
      chk("t5_last",    a_last,        (i == 3));
      cyc();
    end
    chk("t5_end_valid", a_out.valid, 1'b0);

    // Test 2: MSB-first
    b_in.payload = 32'hDDCCBBAA;
    b_in.valid   = 1'b1;
    cyc();
    b_in.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid",   b_out.valid,   1'b1);
      chk("t2_payload", b_out.payload, (32'hDD - 32'h11 * i) & 32'hFF);
      chk("t2_last",    b_last,        (i == 3));
      cyc();
    end
    chk("t2_end_valid", b_out.valid, 1'b0);

    // Test 6a: RATIO=3
    c_in.payload = 24'h332211;
    c_in.valid   = 1'b1;
    cyc();
    c_in.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6c_payload", c_out.payload, 32'h11 * (i + 1));
      chk("t6c_last",    c_last,        (i == 2));
      chk("t6c_ready",   c_in.ready,    (i == 2));
      cyc();
    end
    chk("t6c_end_valid", c_out.valid, 1'b0);

    // Test 6b: RATIO=1 behaves as a register stage
    d_in.payload = 8'hA1;
    d_in.valid   = 1'b1;
    cyc();
    d_in.payload = 8'hA2;
    chk("t6d_payload0", d_out.payload, 8'hA1);
    chk("t6d_last0",    d_last,        1'b1);
    chk("t6d_ready0",   d_in.ready,    1'b1);
    cyc();
    d_in.payload = 8'hA3;
    chk("t6d_payload1", d_out.payload, 8'hA2);
    chk("t6d_last1",    d_last,        1'b1);
    cyc();
    d_in.valid = 1'b0;
    chk("t6d_payload2", d_out.payload, 8'hA3);
    d_out.ready = 1'b0;
    #1 chk("t6d_stall_ready", d_in.ready, 1'b0);
    cyc();
    chk("t6d_hold_valid",   d_out.valid,   1'b1);
    chk("t6d_hold_payload", d_out.payload, 8'hA3);
    d_out.ready = 1'b1;
    cyc();
    chk("t6d_end_valid", d_out.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
